// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-port round-robin arbiter sharing one synchronous-read RAM
//
// Ports:
//   clk, reset              rising-edge clock, synchronous active-high reset
//   req_x/we_x/addr_x/wdata_x  requester x (a = CPU, b = debug/loader); addr bit AW flags out-of-range
//   ack_x, rdata_x          one-cycle completion pulse and held read result per port
//   ram_addr/ram_we/ram_wdata/ram_rdata  single-port RAM, read data valid one cycle after address
//   busy                    high whenever an access is in flight
//   contend_cnt             saturating count of idle cycles with both ports requesting
module mem_arbiter #(
  parameter int AW = 8,
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req_a,
  input  logic          we_a,
  input  logic [AW:0]   addr_a,
  input  logic [DW-1:0] wdata_a,
  input  logic          req_b,
  input  logic          we_b,
  input  logic [AW:0]   addr_b,
  input  logic [DW-1:0] wdata_b,
  output logic          ack_a,
  output logic [DW-1:0] rdata_a,
  output logic          ack_b,
  output logic [DW-1:0] rdata_b,
  output logic [AW-1:0] ram_addr,
  output logic          ram_we,
  output logic [DW-1:0] ram_wdata,
  input  logic [DW-1:0] ram_rdata,
  output logic          busy,
  output logic [7:0]    contend_cnt
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_READ   = 2'd2;
  localparam logic [1:0] S_RESP   = 2'd3;

  logic [1:0]    state_q, state_d;
  logic          gnt_b_q, gnt_b_d;    // granted port: 0 = A, 1 = B
  logic          last_b_q, last_b_d;  // last served port: 0 = A, 1 = B
  logic          we_q, we_d;
  logic [AW:0]   addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [DW-1:0] rdata_a_q, rdata_a_d;
  logic [DW-1:0] rdata_b_q, rdata_b_d;
  logic [7:0]    cnt_q, cnt_d;
  logic          pick_b;

  // B wins when it is alone, or on a tie when A was served last.
  assign pick_b = req_b & (~req_a | ~last_b_q);

  always_comb begin
    state_d   = state_q;
    gnt_b_d   = gnt_b_q;
    last_b_d  = last_b_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rdata_a_d = rdata_a_q;
    rdata_b_d = rdata_b_q;
    cnt_d     = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (req_a && req_b && (cnt_q != 8'hFF)) begin
          cnt_d = cnt_q + 8'd1;
        end
        if (req_a || req_b) begin
          gnt_b_d = pick_b;
          we_d    = pick_b ? we_b    : we_a;
          addr_d  = pick_b ? addr_b  : addr_a;
          wdata_d = pick_b ? wdata_b : wdata_a;
          state_d = S_ACCESS;
        end
      end
      S_ACCESS: state_d = S_READ;
      S_READ: begin
        // RAM data for the address presented in ACCESS is valid now.
        if (!we_q) begin
          if (gnt_b_q) begin
            rdata_b_d = addr_q[AW] ? '0 : ram_rdata;
          end else begin
            rdata_a_d = addr_q[AW] ? '0 : ram_rdata;
          end
        end
        state_d = S_RESP;
      end
      S_RESP: begin
        last_b_d = gnt_b_q;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      gnt_b_q   <= 1'b0;
      last_b_q  <= 1'b1;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      rdata_a_q <= '0;
      rdata_b_q <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      gnt_b_q   <= gnt_b_d;
      last_b_q  <= last_b_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      rdata_a_q <= rdata_a_d;
      rdata_b_q <= rdata_b_d;
      cnt_q     <= cnt_d;
    end
  end

  // Write strobe is decoded from the current state so a write in ACCESS
  // still commits on the edge where reset is sampled.
  assign ram_addr    = addr_q[AW-1:0];
  assign ram_we      = (state_q == S_ACCESS) & we_q & ~addr_q[AW];
  assign ram_wdata   = wdata_q;
  assign ack_a       = (state_q == S_RESP) & ~gnt_b_q;
  assign ack_b       = (state_q == S_RESP) & gnt_b_q;
  assign rdata_a     = rdata_a_q;
  assign rdata_b     = rdata_b_q;
  assign busy        = (state_q != S_IDLE);
  assign contend_cnt = cnt_q;

endmodule
